// File: rtl/calc_seq.sv
// Sequential 8-bit calculator front end: debounced buttons, operand capture,
// and an FSM that drives an external 9-bit adder and registers its result.
module calc_seq #(
    parameter int DEB_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       but_ent,
    input  logic       but_som,
    input  logic       but_sub,
    input  logic       but_clr,
    input  logic [8:0] res_in,
    output logic [8:0] opa,
    output logic [8:0] opb,
    output logic       add_go,
    output logic [8:0] result,
    output logic       ovf,
    output logic       busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        A_IN   = 3'd0,
        OP_SEL = 3'd1,
        B_IN   = 3'd2,
        EXEC   = 3'd3,
        WAIT   = 3'd4,
        SHOW   = 3'd5
    } calcStateT;

    localparam logic [DEB_W-1:0] CNT_MAX = '1;
    localparam logic [DEB_W-1:0] CNT_ONE = DEB_W'(1);

    // Button vector order: {clr, ent, som, sub}
    logic [3:0] rawBtn;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] debLvl;
    logic [3:0] press;
    logic [DEB_W-1:0] debCnt [4];

    assign rawBtn = {but_clr, but_ent, but_som, but_sub};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            debLvl <= '0;
            press  <= '0;
            for (int i = 0; i < 4; i++) begin
                debCnt[i] <= '0;
            end
        end else begin
            sync1 <= rawBtn;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == debLvl[i]) begin
                    debCnt[i] <= '0;
                end else if (debCnt[i] == CNT_MAX) begin
                    // Level held for 2^DEB_W cycles: accept it
                    debLvl[i] <= sync2[i];
                    debCnt[i] <= '0;
                    press[i]  <= sync2[i];
                end else begin
                    debCnt[i] <= debCnt[i] + CNT_ONE;
                end
            end
        end
    end

    logic evClr;
    logic evEnt;
    logic evSom;
    logic evSub;

    assign evClr = press[3];
    assign evEnt = press[2] & ~press[3];
    assign evSom = press[1] & ~|press[3:2];
    assign evSub = press[0] & ~|press[3:1];

    calcStateT state;
    calcStateT nextState;
    logic      opSub;
    logic      clrAll;
    logic      ldASw;
    logic      ldARes;
    logic      ldB;
    logic      ldRes;
    logic      setOp;
    logic [8:0] swExt;

    assign swExt = {sw[7], sw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= A_IN;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        clrAll    = 1'b0;
        ldASw     = 1'b0;
        ldARes    = 1'b0;
        ldB       = 1'b0;
        ldRes     = 1'b0;
        setOp     = 1'b0;
        add_go    = 1'b0;
        if (state == EXEC) begin
            add_go = 1'b1;
        end
        if (evClr) begin
            clrAll    = 1'b1;
            nextState = A_IN;
        end else begin
            case (state)
                A_IN: begin
                    if (evEnt) begin
                        ldASw     = 1'b1;
                        nextState = OP_SEL;
                    end
                end
                OP_SEL: begin
                    if (evSom | evSub) begin
                        setOp     = 1'b1;
                        nextState = B_IN;
                    end
                end
                B_IN: begin
                    if (evEnt) begin
                        ldB       = 1'b1;
                        nextState = EXEC;
                    end
                end
                EXEC: nextState = WAIT;
                WAIT: begin
                    ldRes     = 1'b1;
                    nextState = SHOW;
                end
                SHOW: begin
                    if (evSom | evSub) begin
                        ldARes    = 1'b1;
                        setOp     = 1'b1;
                        nextState = B_IN;
                    end else if (evEnt) begin
                        ldASw     = 1'b1;
                        nextState = OP_SEL;
                    end
                end
                default: nextState = A_IN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            ovf    <= 1'b0;
            opSub  <= 1'b0;
        end else if (clrAll) begin
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            ovf    <= 1'b0;
            opSub  <= 1'b0;
        end else begin
            if (ldASw) begin
                opa <= swExt;
            end else if (ldARes) begin
                opa <= result;
            end
            if (setOp) begin
                opSub <= evSub;
            end
            if (ldB) begin
                opb <= opSub ? (~swExt + 9'd1) : swExt;
            end
            if (ldRes) begin
                result <= res_in;
                ovf    <= (opa[8] == opb[8]) & (res_in[8] != opa[8]);
            end
        end
    end

    assign busy      = (state == EXEC) || (state == WAIT);
    assign state_dbg = state;

endmodule

// File: doc/calc_seq.md
CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 Parameter DEB_W, default 4: debounce counter width; a button level must be stable for 2^DEB_W consecutive clk cycles to be accepted.
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 sw  in  8  operand switches, two's complement.
REQ-005 but_ent  in  1  enter-operand button, raw and asynchronous.
REQ-006 but_som  in  1  add button, raw.
REQ-007 but_sub  in  1  subtract button, raw.
REQ-008 but_clr  in  1  clear button, raw.
REQ-009 res_in  in  9  sum returned by the external 9-bit two's-complement adder.
REQ-010 opa  out  9  adder operand A.
REQ-011 opb  out  9  adder operand B, already negated for subtract.
REQ-012 add_go  out  1  one-cycle strobe launching the adder.
REQ-013 result  out  9  registered calculation result.
REQ-014 ovf  out  1  signed overflow of the last operation.
REQ-015 busy  out  1  high in EXEC and WAIT.
REQ-016 state_dbg  out  3  current FSM state encoding.

Function
REQ-017 Each button SHALL pass a 2-FF synchronizer, then a DEB_W-bit stability counter; a debounced 0->1 transition SHALL produce exactly one single-cycle press event.
REQ-018 Press events in the same cycle SHALL be prioritized clr > ent > som > sub; lower-priority events that cycle SHALL be discarded.
REQ-019 FSM states and encodings: A_IN=0, OP_SEL=1, B_IN=2, EXEC=3, WAIT=4, SHOW=5; encodings 6 and 7 SHALL return to A_IN on the next clock.
REQ-020 A_IN: ent latches opa = sign-extend(sw) and moves to OP_SEL; all other presses except clr are ignored.
REQ-021 OP_SEL: som records op=add, sub records op=sub, then move to B_IN; ent is ignored.
REQ-022 B_IN: ent latches B = sign-extend(sw); opb = B for add, opb = (~B)+1 (9-bit) for sub; then move to EXEC.
REQ-023 EXEC: add_go=1 for exactly this cycle; next state WAIT.
REQ-024 WAIT: res_in is sampled at the end of this cycle into result.
- ovf = (opa[8]==opb[8]) & (res_in[8]!=opa[8]).
- Next state SHOW.
REQ-025 opa and opb SHALL be held stable from entry to EXEC until exit from WAIT.
REQ-026 All presses except clr SHALL be ignored while busy=1.
REQ-027 SHOW, on som or sub: chain, with opa = result; record the op; move to B_IN.
REQ-028 SHOW, on ent: opa = sign-extend(sw); move to OP_SEL.
REQ-029 clr in any state: next cycle, state=A_IN and opa, opb, result, ovf all 0.
REQ-030 Latency: ent event in B_IN at cycle n -> add_go at n+1 -> result/ovf valid at n+3, with state=SHOW.
REQ-031 result and ovf SHALL change only in WAIT or on clr/reset.

Reset
REQ-032 While rst_n=0, asynchronously:
- state=A_IN; opa, opb, result = 0; ovf=0; add_go=0; busy=0.
- Synchronizers and debounce counters cleared.
REQ-033 Reset asserted mid-operation, including EXEC or WAIT, SHALL abort it with no add_go on release.
REQ-034 A button held low->high across reset release SHALL generate at most one press after full debounce.

Verification
REQ-035 A: sw=0x05 ent, som, sw=0x03 ent -> add_go one cycle with opa=0x005, opb=0x003; result=0x008, ovf=0.
REQ-036 B: sw=0x7F ent, sub, sw=0x80 ent -> opb=0x080; result=0x0FF, ovf=0.
REQ-037 C: from SHOW with result=0x0FF, som, sw=0x01 ent -> opa=0x0FF, opb=0x001; result=0x100, ovf=1.
REQ-038 D: bounce but_ent with pulses shorter than 2^DEB_W cycles, then a clean hold -> exactly one press event and one state advance.
REQ-039 E: clr and ent press events in the same cycle while in B_IN -> state=A_IN, outputs zeroed, no add_go.
REQ-040 F: rst_n low during WAIT -> outputs zeroed immediately, no result update, state_dbg=0 after release.
